t5_mdu: RTL and testbench

Iterative, XLEN-parametrised RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the tra5 execute stage. It sits beside t5_aslu and takes the same decode-stage operands (`dop1`, `dop2`) and `dfn3`. It stalls the pipeline through `xbsy` while computing, then presents the result for one cycle with `xrdy`. Throughput and area are traded via `UNROLL`, the number of bits retired per cycle.

---
 rtl/t5_pkg.sv | 22 ++
 rtl/t5_mdu_step.sv | 36 +++
 rtl/t5_mdu.sv | 121 ++++++++++++
 tb/tb_t5_mdu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t5_pkg.sv
// Shared tra5 definitions: M-extension funct3 codes, MDU FSM encoding, OP opcode.
// Constants only, no timing or backpressure of its own.
package t5_pkg;

    localparam logic [4:0] OP = 5'b01100;

    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/t5_mdu_step.sv
// One combinational MDU iteration: shift-add multiply step or restoring-divide step.
// Zero latency; no flow control, the parent decides when to register the result.
module t5_mdu_step #(
    parameter int XLEN = 32
) (
    input  logic            div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_nxt,
    output logic [XLEN-1:0] lo_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        sh     = {hi, lo[XLEN-1]};
        diff   = sh - {1'b0, opnd};
        hi_nxt = sum[XLEN:1];
        lo_nxt = {sum[0], lo[XLEN-1:1]};
        if (div) begin
            // partial remainder < divisor, so diff[XLEN] is an exact borrow flag
            if (!diff[XLEN]) begin
                hi_nxt = diff[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = sh[XLEN-1:0];
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/t5_mdu.sv
// Iterative RV M-extension unit; latency XLEN/UNROLL+1 cycles, 1 for div-by-zero/overflow.
// Stalls the pipe via registered xbsy while iterating; xrdy is a one-cycle result pulse.
module t5_mdu
    import t5_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic            dstb,
    input  logic [2:0]      dfn3,
    input  logic [XLEN-1:0] dop1,
    input  logic [XLEN-1:0] dop2,
    output logic            xbsy,
    output logic            xrdy,
    output logic [XLEN-1:0] xmdu
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = $clog2(N + 1);

    mdu_state_t      state, state_nxt;
    logic [2:0]      fn_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q;
    logic            neg_q;
    logic [CW-1:0]   cnt_q;

    logic            acc, last;
    logic            sgn1, sgn2, dz, ovf, spec, neg_in;
    logic [XLEN-1:0] mag1, mag2, spec_res, res, div_val;
    logic [2*XLEN-1:0] prod;

    logic [XLEN-1:0] ch_hi [UNROLL+1];
    logic [XLEN-1:0] ch_lo [UNROLL+1];

    assign ch_hi[0] = hi_q;
    assign ch_lo[0] = lo_q;

    for (genvar i = 0; i < UNROLL; i++) begin : g_step
        t5_mdu_step #(.XLEN(XLEN)) u_step (
            .div    (fn_q[2]),
            .hi     (ch_hi[i]),
            .lo     (ch_lo[i]),
            .opnd   (opnd_q),
            .hi_nxt (ch_hi[i+1]),
            .lo_nxt (ch_lo[i+1])
        );
    end

    always_comb begin
        acc      = sena & dstb & (state != MDU_CALC);
        sgn1     = dop1[XLEN-1] & (dfn3 inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM});
        sgn2     = dop2[XLEN-1] & (dfn3 inside {MDU_MULH, MDU_DIV, MDU_REM});
        mag1     = sgn1 ? -dop1 : dop1;
        mag2     = sgn2 ? -dop2 : dop2;
        dz       = dfn3[2] & (dop2 == '0);
        ovf      = ((dfn3 == MDU_DIV) | (dfn3 == MDU_REM))
                 & (dop1 == {1'b1, {(XLEN-1){1'b0}}}) & (&dop2);
        spec     = dz | ovf;
        spec_res = dz ? (dfn3[1] ? dop1 : '1) : (dfn3[1] ? '0 : dop1);
        // remainder follows the dividend; everything else follows the sign product
        neg_in   = (dfn3[2] & dfn3[1]) ? sgn1 : (sgn1 ^ sgn2);
        last     = (cnt_q == CW'(N - 1));

        prod     = {ch_hi[UNROLL], ch_lo[UNROLL]};
        prod     = neg_q ? -prod : prod;
        div_val  = fn_q[1] ? ch_hi[UNROLL] : ch_lo[UNROLL];
        div_val  = neg_q ? -div_val : div_val;
        if (fn_q[2])
            res = div_val;
        else if (fn_q == MDU_MUL)
            res = prod[XLEN-1:0];
        else
            res = prod[2*XLEN-1:XLEN];

        state_nxt = state;
        case (state)
            MDU_IDLE, MDU_DONE: state_nxt = acc ? (spec ? MDU_DONE : MDU_CALC) : MDU_IDLE;
            MDU_CALC:           if (last) state_nxt = MDU_DONE;
            default:            state_nxt = MDU_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state  <= MDU_IDLE;
            xbsy   <= 1'b0;
            xrdy   <= 1'b0;
            xmdu   <= '0;
            fn_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            neg_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            xbsy  <= (state_nxt == MDU_CALC);
            xrdy  <= (state_nxt == MDU_DONE);
            if (acc) begin
                fn_q   <= dfn3;
                neg_q  <= neg_in;
                hi_q   <= '0;
                lo_q   <= dfn3[2] ? mag1 : mag2;
                opnd_q <= dfn3[2] ? mag2 : mag1;
                cnt_q  <= '0;
                if (spec)
                    xmdu <= spec_res;
            end else if (state == MDU_CALC) begin
                hi_q  <= ch_hi[UNROLL];
                lo_q  <= ch_lo[UNROLL];
                cnt_q <= cnt_q + 1'b1;
                if (last)
                    xmdu <= res;
            end
        end
    end

endmodule

// File: tb/tb_t5_mdu.sv
// Randomised scoreboard bench for t5_mdu at UNROLL 1, 2 and 4 side by side.
// Checks result value, accept-to-xrdy latency and reset/abort behaviour.
module tb_t5_mdu;
    import t5_pkg::*;

    localparam int XL = 32;

    logic        sclk = 1'b0;
    logic        srst;
    logic        sena [3];
    logic        dstb [3];
    logic [2:0]  dfn3 [3];
    logic [31:0] dop1 [3];
    logic [31:0] dop2 [3];
    logic        xbsy [3];
    logic        xrdy [3];
    logic [31:0] xmdu [3];

    typedef struct {
        logic [31:0] val;
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sb [3][$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        t5_mdu #(.XLEN(XL), .UNROLL(1 << g)) u_dut (
            .sclk (sclk),
            .srst (srst),
            .sena (sena[g]),
            .dstb (dstb[g]),
            .dfn3 (dfn3[g]),
            .dop1 (dop1[g]),
            .dop2 (dop2[g]),
            .xbsy (xbsy[g]),
            .xrdy (xrdy[g]),
            .xmdu (xmdu[g])
        );
    end

    function automatic logic [31:0] ref_mdu(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb_;
        logic [63:0] p;
        sa  = longint'(signed'(a));
        sb_ = longint'(signed'(b));
        case (fn)
            MDU_MUL:    begin p = sa * sb_; return p[31:0]; end
            MDU_MULH:   begin p = sa * sb_; return p[63:32]; end
            MDU_MULHSU: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            MDU_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            MDU_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb_; return p[31:0];
            end
            MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MDU_REM:    begin
                if (b == 0) return a;
                p = sa % sb_; return p[31:0];
            end
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_spec(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        return fn[2] && (b == 0 ||
               ((fn == MDU_DIV || fn == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Waits for the unit to be free (random junk on dstb meanwhile), then presents one op.
    task automatic issue(input int d, input logic [2:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input bit track);
        int guard = 0;
        while (xbsy[d] === 1'b1) begin
            dstb[d] = 1'($urandom_range(0, 1));
            dfn3[d] = 3'($urandom);
            dop1[d] = $urandom;
            dop2[d] = $urandom;
            @(negedge sclk);
            guard++;
            if (guard > 100) begin
                nvec++; nerr++;
                $display("FAIL busy_timeout dut%0d: xbsy still %b after %0d cycles, required 0", d, xbsy[d], guard);
                dstb[d] = 1'b0;
                return;
            end
        end
        sena[d] = 1'b1;
        dstb[d] = 1'b1;
        dfn3[d] = fn;
        dop1[d] = a;
        dop2[d] = b;
        if (track)
            sb[d].push_back('{expv, fn, a, b, cyc, is_spec(fn, a, b) ? 1 : (XL >> d) + 1});
        @(negedge sclk);
        dstb[d] = 1'b0;
    endtask

    task automatic check_idle(input string name);
        for (int d = 0; d < 3; d++) begin
            nvec++;
            if (xbsy[d] !== 1'b0 || xrdy[d] !== 1'b0 || xmdu[d] !== 32'h0) begin
                nerr++;
                $display("FAIL %s dut%0d: got xbsy=%b xrdy=%b xmdu=%h, required 0 0 00000000",
                         name, d, xbsy[d], xrdy[d], xmdu[d]);
            end
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 ||
               xbsy[0] || xbsy[1] || xbsy[2]) begin
            @(negedge sclk);
            guard++;
            if (guard > 500) begin
                nvec++; nerr++;
                $display("FAIL drain_timeout: %0d/%0d/%0d results outstanding, required 0",
                         sb[0].size(), sb[1].size(), sb[2].size());
                sb[0].delete(); sb[1].delete(); sb[2].delete();
                return;
            end
        end
        repeat (2) @(negedge sclk);
    endtask

    always @(negedge sclk) begin
        if (!srst) begin
            for (int d = 0; d < 3; d++) begin
                if (xrdy[d]) begin
                    nvec++;
                    if (sb[d].size() == 0) begin
                        nerr++;
                        $display("FAIL unexpected_xrdy dut%0d: got xmdu=%h, required no result", d, xmdu[d]);
                    end else begin
                        exp_t e;
                        e = sb[d].pop_front();
                        if (xmdu[d] !== e.val || (cyc - e.t0) != e.lat || xbsy[d] !== 1'b0) begin
                            nerr++;
                            $display("FAIL result dut%0d fn=%0d a=%h b=%h: got %h lat %0d bsy %b, required %h lat %0d bsy 0",
                                     d, e.fn, e.a, e.b, xmdu[d], cyc - e.t0, xbsy[d], e.val, e.lat);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  fn;
        logic [31:0] a, b;
        srst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            sena[d] = 1'b1; dstb[d] = 1'b0; dfn3[d] = '0; dop1[d] = '0; dop2[d] = '0;
        end
        repeat (3) @(negedge sclk);
        check_idle("reset_state");
        srst = 1'b0;
        @(negedge sclk);

        issue(0, MDU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
        issue(0, MDU_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1);
        issue(0, MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        issue(0, MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        issue(0, MDU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1);
        issue(0, MDU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1);
        issue(0, MDU_DIVU,   32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, 1);
        issue(0, MDU_REMU,   32'hFFFF_FFFF,  32'h10,        32'h0000_000F, 1);
        issue(0, MDU_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        issue(0, MDU_REM,    32'd5,          32'd0,         32'd5,         1);
        issue(0, MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue(0, MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1);
        for (int d = 1; d < 3; d++) begin
            issue(d, MDU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
            issue(d, MDU_DIVU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 1);
            issue(d, MDU_REM,  32'd5,         32'd0,         32'd5,         1);
        end
        drain();

        issue(0, MDU_DIVU, 32'h1234_5678, 32'd3, 32'h0, 0);
        repeat (9) @(negedge sclk);
        srst = 1'b1;
        @(negedge sclk);
        check_idle("reset_abort");
        srst = 1'b0;
        repeat (3) @(negedge sclk);
        issue(0, MDU_MUL, 32'd3, 32'd4, 32'd12, 1);
        drain();

        // sena low must block acceptance entirely
        sena[0] = 1'b0; dstb[0] = 1'b1; dfn3[0] = MDU_DIVU; dop1[0] = 32'd9; dop2[0] = 32'd0;
        repeat (4) @(negedge sclk);
        nvec++;
        if (xbsy[0] !== 1'b0 || xrdy[0] !== 1'b0) begin
            nerr++;
            $display("FAIL sena_gate: got xbsy=%b xrdy=%b, required 0 0", xbsy[0], xrdy[0]);
        end
        dstb[0] = 1'b0; sena[0] = 1'b1;
        @(negedge sclk);

        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < ((d == 0) ? 120 : 60); k++) begin
                fn = 3'($urandom_range(0, 7));
                a  = pick();
                b  = pick();
                if ($urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 3)) @(negedge sclk);
                issue(d, fn, a, b, ref_mdu(fn, a, b), 1);
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
